// File: rtl/stream_mux_arb_if.sv
// stream_mux_arb_if: N-channel valid/ready input bundle plus the single muxed output stream
interface stream_mux_arb_if #(
  parameter int WIDTH = 8,
  parameter int NCH = 4
);
  localparam int SELW = $clog2(NCH);
  logic mode;
  logic [SELW-1:0] sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_ready;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [SELW-1:0] out_ch;
  modport slave (
    input mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N:1 valid/ready mux, fixed select or round-robin, one registered output stage
module stream_mux_arb #(
  parameter int WIDTH = 8,
  parameter int NCH = 4
) (
  input logic clk,
  input logic rst,
  stream_mux_arb_if.slave s
);
  localparam int SELW = $clog2(NCH);
  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST = SELW'(NCH-1);
  logic [SELW-1:0] rr_ptr, rr_gnt, gnt, k;
  logic gnt_vld, ld, sel_ok;
  int j;
  // scan from the far end back to rr_ptr so the closest valid channel wins
  always_comb begin
    rr_gnt = rr_ptr;
    j = 0;
    k = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      j = (j >= NCH) ? j - NCH : j;
      k = SELW'(j);
      rr_gnt = s.in_valid[k] ? k : rr_gnt;
    end
  end
  assign sel_ok = {1'b0, s.sel} < NCH_W;
  assign gnt = s.mode ? rr_gnt : s.sel;
  assign gnt_vld = s.mode ? |s.in_valid : (sel_ok & s.in_valid[s.sel]);
  assign ld = !s.out_valid | s.out_ready;
  assign s.in_ready = (ld & gnt_vld & !rst) ? (NCH'(1) << gnt) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s.out_valid <= 1'b0;
      s.out_data <= '0;
      s.out_ch <= '0;
      rr_ptr <= '0;
    end else if (ld) begin
      s.out_valid <= gnt_vld;
      if (gnt_vld) begin
        s.out_data <= s.in_data[int'(gnt)*WIDTH +: WIDTH];
        s.out_ch <= gnt;
      end
      if (gnt_vld & s.mode) rr_ptr <= (gnt == LAST) ? '0 : gnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed table for a 4x8 instance plus a randomised 3x5 instance against a behavioural model
module tb_stream_mux_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  stream_mux_arb_if #(.WIDTH(8), .NCH(4)) a ();
  stream_mux_arb_if #(.WIDTH(5), .NCH(3)) b ();
  stream_mux_arb #(.WIDTH(8), .NCH(4)) u_a (.clk(clk), .rst(rst), .s(a));
  stream_mux_arb #(.WIDTH(5), .NCH(3)) u_b (.clk(clk), .rst(rst), .s(b));
  typedef struct {
    logic mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic ordy;
    logic [3:0] eir;
    logic ev;
    logic [7:0] ed;
    logic [1:0] ech;
  } vec_t;
  vec_t vt[$];
  int passed = 0;
  int total = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic void add(input logic m, input logic [1:0] sl, input logic [3:0] iv, input logic ordy,
                              input logic [3:0] eir, input logic ev, input logic [7:0] ed, input logic [1:0] ech);
    vec_t v;
    v.mode = m; v.sel = sl; v.iv = iv; v.ordy = ordy;
    v.eir = eir; v.ev = ev; v.ed = ed; v.ech = ech;
    vt.push_back(v);
  endfunction
  logic m_v;
  logic [4:0] m_d;
  logic [1:0] m_ch, m_rr, g, kk;
  logic gv, ld, found;
  logic [2:0] eir;
  initial begin
    a.mode = 1'b1; a.sel = '0; a.in_valid = 4'hF; a.out_ready = 1'b1;
    a.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b.mode = 1'b0; b.sel = '0; b.in_valid = '0; b.out_ready = 1'b1; b.in_data = '0;
    // round-robin from reset, then skip pattern 1010
    add(1, 0, 4'hF, 1, 4'b0001, 1, 8'hA0, 0);
    add(1, 0, 4'hF, 1, 4'b0010, 1, 8'hA1, 1);
    add(1, 0, 4'hF, 1, 4'b0100, 1, 8'hA2, 2);
    add(1, 0, 4'hF, 1, 4'b1000, 1, 8'hA3, 3);
    add(1, 0, 4'hF, 1, 4'b0001, 1, 8'hA0, 0);
    add(1, 0, 4'hF, 1, 4'b0010, 1, 8'hA1, 1);
    add(1, 0, 4'hA, 1, 4'b1000, 1, 8'hA3, 3);
    add(1, 0, 4'hA, 1, 4'b0010, 1, 8'hA1, 1);
    add(1, 0, 4'hA, 1, 4'b1000, 1, 8'hA3, 3);
    add(1, 0, 4'hA, 1, 4'b0010, 1, 8'hA1, 1);
    // fixed select, then backpressure and release
    add(0, 2, 4'hF, 1, 4'b0100, 1, 8'hA2, 2);
    add(0, 2, 4'hF, 1, 4'b0100, 1, 8'hA2, 2);
    add(0, 1, 4'hF, 0, 4'b0000, 1, 8'hA2, 2);
    add(0, 1, 4'hF, 0, 4'b0000, 1, 8'hA2, 2);
    add(0, 1, 4'hF, 0, 4'b0000, 1, 8'hA2, 2);
    add(0, 1, 4'hF, 1, 4'b0010, 1, 8'hA1, 1);
    // rr_ptr held through mode 0, drain, load into empty stage with out_ready low
    add(1, 0, 4'hF, 1, 4'b0100, 1, 8'hA2, 2);
    add(1, 0, 4'h0, 1, 4'b0000, 0, 8'hA2, 2);
    add(1, 0, 4'h1, 0, 4'b0001, 1, 8'hA0, 0);
    add(1, 0, 4'h1, 0, 4'b0000, 1, 8'hA0, 0);
    add(1, 0, 4'h0, 1, 4'b0000, 0, 8'hA0, 0);
    add(0, 3, 4'h7, 1, 4'b0000, 0, 8'hA0, 0);
    #3;
    check("rst_in_ready", 32'(a.in_ready), 0);
    check("rst_out_valid", 32'(a.out_valid), 0);
    check("rst_out_ch", 32'(a.out_ch), 0);
    check("rst_out_data", 32'(a.out_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      a.mode = vt[i].mode; a.sel = vt[i].sel; a.in_valid = vt[i].iv; a.out_ready = vt[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(a.in_ready), 32'(vt[i].eir));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(a.out_valid), 32'(vt[i].ev));
      check($sformatf("v%0d_out_data", i), 32'(a.out_data), 32'(vt[i].ed));
      check($sformatf("v%0d_out_ch", i), 32'(a.out_ch), 32'(vt[i].ech));
      @(negedge clk);
    end
    // reset mid-operation discards the registered word and rewinds rr_ptr
    a.mode = 1'b1; a.in_valid = 4'hF; a.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("mid_load_valid", 32'(a.out_valid), 1);
    check("mid_load_ch", 32'(a.out_ch), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(a.out_valid), 0);
    check("mid_rst_ch", 32'(a.out_ch), 0);
    check("mid_rst_in_ready", 32'(a.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    a.out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(a.in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post_rst_ch", 32'(a.out_ch), 0);
    check("post_rst_data", 32'(a.out_data), 32'hA0);
    @(negedge clk);
    // randomised run on the 3-channel instance
    m_v = 1'b0; m_d = '0; m_ch = '0; m_rr = '0;
    for (int c = 0; c < 1000; c++) begin
      b.mode = 1'($urandom_range(0, 1));
      b.sel = 2'($urandom_range(0, 3));
      b.in_valid = 3'($urandom_range(0, 7));
      b.out_ready = ($urandom_range(0, 3) != 0);
      b.in_data = 15'($urandom);
      #1;
      ld = !m_v | b.out_ready;
      g = b.sel;
      gv = 1'b0;
      if (!b.mode) gv = (b.sel < 2'd3) && b.in_valid[b.sel];
      else begin
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
          kk = 2'((int'(m_rr) + i) % 3);
          if (!found && b.in_valid[kk]) begin g = kk; found = 1'b1; end
        end
        gv = found;
      end
      eir = (ld && gv) ? (3'b001 << g) : 3'b000;
      check($sformatf("r%0d_in_ready", c), 32'(b.in_ready), 32'(eir));
      @(posedge clk);
      if (ld) begin
        m_v = gv;
        if (gv) begin
          m_d = b.in_data[int'(g)*5 +: 5];
          m_ch = g;
          if (b.mode) m_rr = 2'((int'(g) + 1) % 3);
        end
      end
      #1;
      check($sformatf("r%0d_out_valid", c), 32'(b.out_valid), 32'(m_v));
      check($sformatf("r%0d_out_data", c), 32'(b.out_data), 32'(m_d));
      check($sformatf("r%0d_out_ch", c), 32'(b.out_ch), 32'(m_ch));
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
